// File: rtl/mux_8way_16_pkg.sv
// Shared widths and types for the registered 8-way 16-bit multiplexer.
// The one-hot helper is only consumed when MUX8WAY16_SEL_ONEHOT_EN is defined.
package mux8way16_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 3;
    localparam int NUM_IN = 1 << SEL_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [SEL_W-1:0]  sel_t;
    typedef logic [NUM_IN-1:0] onehot_t;

    function automatic onehot_t sel_onehot(input sel_t sel);
        onehot_t oh;
        oh = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mux_8way_16_mux2way16.sv
// Combinational 2:1 word mux; one node of the 8-way selection tree.
module mux2way16
    import mux8way16_pkg::*;
(
    input  word_t A,
    input  word_t B,
    input  logic  SEL,
    output word_t OUT
);

    assign OUT = SEL ? B : A;

endmodule

// File: rtl/mux_8way_16.sv
// Registered 8-to-1 mux of 16-bit words built from a 7-node 2:1 tree.
// Optional registered one-hot select output: define MUX8WAY16_SEL_ONEHOT_EN.
// There is no handshake: OUT is a plain pipeline register updated every cycle.
module mux_8way_16
    import mux8way16_pkg::*;
(
    input  logic  CLK,
    input  logic  RST_N,
    input  word_t A,
    input  word_t B,
    input  word_t C,
    input  word_t D,
    input  word_t E,
    input  word_t F,
    input  word_t G,
    input  word_t H,
    input  sel_t  SEL,
`ifdef MUX8WAY16_SEL_ONEHOT_EN
    output onehot_t SEL_OH,
`endif
    output word_t OUT
);

    word_t ab, cd, ef, gh;
    word_t abcd, efgh;
    word_t next_word;

    // Leaves: SEL[0] chooses within each pair.
    mux2way16 u_leaf_ab (.A(A), .B(B), .SEL(SEL[0]), .OUT(ab));
    mux2way16 u_leaf_cd (.A(C), .B(D), .SEL(SEL[0]), .OUT(cd));
    mux2way16 u_leaf_ef (.A(E), .B(F), .SEL(SEL[0]), .OUT(ef));
    mux2way16 u_leaf_gh (.A(G), .B(H), .SEL(SEL[0]), .OUT(gh));

    // Middle: SEL[1] chooses between pair results; root: SEL[2] picks the half.
    mux2way16 u_mid_lo  (.A(ab),   .B(cd),   .SEL(SEL[1]), .OUT(abcd));
    mux2way16 u_mid_hi  (.A(ef),   .B(gh),   .SEL(SEL[1]), .OUT(efgh));
    mux2way16 u_root    (.A(abcd), .B(efgh), .SEL(SEL[2]), .OUT(next_word));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT <= '0;
        end else begin
            OUT <= next_word;
        end
    end

`ifdef MUX8WAY16_SEL_ONEHOT_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            SEL_OH <= '0;
        end else begin
            SEL_OH <= sel_onehot(SEL);
        end
    end
`endif

endmodule

// File: tb/tb_mux_8way_16.sv
// Scoreboard bench for mux_8way_16: driver pushes expected words, monitor pops after each edge.
module tb_mux_8way_16;

    logic        CLK;
    logic        RST_N;
    logic        clk_en;
    logic [15:0] d [8];
    logic [2:0]  SEL;
    logic [15:0] OUT;
`ifdef MUX8WAY16_SEL_ONEHOT_EN
    logic [7:0]  sel_oh;
`endif

    // Upper byte holds the expected one-hot select, lower 16 bits the expected OUT.
    logic [23:0] exp_q[$];
    int checks;
    int errors;

    mux_8way_16 dut (
        .CLK(CLK), .RST_N(RST_N),
        .A(d[0]), .B(d[1]), .C(d[2]), .D(d[3]),
        .E(d[4]), .F(d[5]), .G(d[6]), .H(d[7]),
        .SEL(SEL),
`ifdef MUX8WAY16_SEL_ONEHOT_EN
        .SEL_OH(sel_oh),
`endif
        .OUT(OUT)
    );

    // Clock / reset block
    initial CLK = 1'b0;
    always #5 if (clk_en) CLK = ~CLK;

    task automatic check_now(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, want);
        end
    endtask

    // Driver: at the falling edge set SEL, overwrite the inputs in mask with val,
    // and queue what the next rising edge must capture.
    task automatic drive(input logic [2:0] s, input logic [7:0] mask,
                         input logic [15:0] val, input logic [15:0] exp_out,
                         input logic [7:0] exp_oh);
        @(negedge CLK);
        SEL = s;
        for (int i = 0; i < 8; i++) if (mask[i]) d[i] = val;
        exp_q.push_back({exp_oh, exp_out});
    endtask

    // Monitor / scoreboard
    initial begin
        logic [23:0] e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (OUT !== e[15:0]) begin
                    errors++;
                    $display("FAIL out got %h expected %h sel %0d", OUT, e[15:0], SEL);
                end
`ifdef MUX8WAY16_SEL_ONEHOT_EN
                checks++;
                if (sel_oh !== e[23:16]) begin
                    errors++;
                    $display("FAIL sel_oh got %b expected %b", sel_oh, e[23:16]);
                end
`endif
            end
        end
    end

    initial begin
        clk_en = 1'b0;
        RST_N  = 1'b0;
        SEL    = 3'd2;
        d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h5A5A; d[3] = 16'h4444;
        d[4] = 16'h5555; d[5] = 16'h6666; d[6] = 16'h7777; d[7] = 16'h8888;

        // Reset with no clock running
        #3;
        check_now("reset_no_clk", OUT, 16'h0000);
`ifdef MUX8WAY16_SEL_ONEHOT_EN
        check_now("reset_oh", {8'h00, sel_oh}, 16'h0000);
`endif
        clk_en = 1'b1;
        @(negedge CLK);
        RST_N = 1'b1;
        drive(3'd2, 8'h00, 16'h0000, 16'h5A5A, 8'b0000_0100);

        // One-hot sweep with a mid-run reset at SEL=3
        drive(3'd0, 8'h01, 16'h0001, 16'h0001, 8'b0000_0001);
        drive(3'd1, 8'h02, 16'h0002, 16'h0002, 8'b0000_0010);
        drive(3'd2, 8'h04, 16'h0004, 16'h0004, 8'b0000_0100);
        d[3] = 16'h0008; d[4] = 16'h0010; d[5] = 16'h0020; d[6] = 16'h0040; d[7] = 16'h0080;
        drive(3'd3, 8'h00, 16'h0000, 16'h0008, 8'b0000_1000);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check_now("mid_reset_out", OUT, 16'h0000);
`ifdef MUX8WAY16_SEL_ONEHOT_EN
        check_now("mid_reset_oh", {8'h00, sel_oh}, 16'h0000);
`endif
        RST_N = 1'b1;
        drive(3'd3, 8'h00, 16'h0000, 16'h0008, 8'b0000_1000);
        drive(3'd4, 8'h00, 16'h0000, 16'h0010, 8'b0001_0000);
        drive(3'd5, 8'h00, 16'h0000, 16'h0020, 8'b0010_0000);
        drive(3'd6, 8'h00, 16'h0000, 16'h0040, 8'b0100_0000);
        drive(3'd7, 8'h00, 16'h0000, 16'h0080, 8'b1000_0000);

        // Unselected isolation
        drive(3'd5, 8'h20, 16'hBEEF, 16'hBEEF, 8'b0010_0000);
        drive(3'd5, 8'h1F, 16'hFFFF, 16'hBEEF, 8'b0010_0000);
        drive(3'd5, 8'hC0, 16'hFFFF, 16'hBEEF, 8'b0010_0000);
        drive(3'd5, 8'h00, 16'h0000, 16'hBEEF, 8'b0010_0000);

        // Data follow on H
        drive(3'd7, 8'h80, 16'h1234, 16'h1234, 8'b1000_0000);
        drive(3'd7, 8'h80, 16'hA5A5, 16'hA5A5, 8'b1000_0000);
        drive(3'd7, 8'h00, 16'h0000, 16'hA5A5, 8'b1000_0000);

        // Simultaneous SEL and data change
        drive(3'd1, 8'h02, 16'hC3C3, 16'hC3C3, 8'b0000_0010);
        drive(3'd6, 8'h40, 16'h8001, 16'h8001, 8'b0100_0000);
        drive(3'd0, 8'h01, 16'h7FFE, 16'h7FFE, 8'b0000_0001);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
